seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/seg_scan_ctrl_pkg.sv | 26 ++
 rtl/seg_scan_ctrl_if.sv | 17 +
 rtl/seg_scan_ctrl_decoder.sv | 56 +++++
 rtl/seg_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg_pkg : shared 7-segment constants and polarity helper          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Converts an active-high segment pattern to the pin polarity.
  function automatic logic [6:0] seg_polarity(input logic [6:0] seg_hi,
                                              input logic       active_low);
    return active_low ? ~seg_hi : seg_hi;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg_scan_ctrl_if : display value load/ack handshake               |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load_ack;

  modport master (output load, value, dp_in, input load_ack);
  modport slave  (input load, value, dp_in, output load_ack);
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decoder : hex nibble to active-high 7-segment pattern             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module decoder
  import seg_pkg::*;
(
  input  logic x3,
  input  logic x2,
  input  logic x1,
  input  logic x0,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g
);

  logic [6:0] w_pat;

  always_comb begin
    w_pat = SEG_OFF;
    case ({x3, x2, x1, x0})
      4'h0: w_pat = 7'h3F;
      4'h1: w_pat = 7'h06;
      4'h2: w_pat = 7'h5B;
      4'h3: w_pat = 7'h4F;
      4'h4: w_pat = 7'h66;
      4'h5: w_pat = 7'h6D;
      4'h6: w_pat = 7'h7D;
      4'h7: w_pat = 7'h07;
      4'h8: w_pat = 7'h7F;
      4'h9: w_pat = 7'h6F;
      4'hA: w_pat = 7'h77;
      4'hB: w_pat = 7'h7C;
      4'hC: w_pat = 7'h39;
      4'hD: w_pat = 7'h5E;
      4'hE: w_pat = 7'h79;
      4'hF: w_pat = 7'h71;
      default: w_pat = SEG_OFF;
    endcase
  end

  assign a = w_pat[SEG_A];
  assign b = w_pat[SEG_B];
  assign c = w_pat[SEG_C];
  assign d = w_pat[SEG_D];
  assign e = w_pat[SEG_E];
  assign f = w_pat[SEG_F];
  assign g = w_pat[SEG_G];

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg_scan_ctrl : multiplexed N-digit 7-segment scan controller     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  blank_lz,
  seg_scan_ctrl_if.slave        host,
  output logic                  frame_tick,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      c_last_cnt = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      c_blank    = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]      c_last_idx = IDX_W'(NUM_DIGITS - 1);
  localparam logic                  c_seg_lo   = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] c_an_off   = (AN_ACTIVE_LOW != 0) ?
                                                 {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_pending;
  logic                    r_load_ack;

  logic                    w_slot_end;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_dp_bit;
  logic [6:0]              w_dec;
  logic [NUM_DIGITS-1:1]   w_zero_above;
  logic [NUM_DIGITS-1:0]   w_supp;
  logic [NUM_DIGITS-1:0]   w_an_on;

  assign w_slot_end    = enable && (r_cnt == c_last_cnt);
  assign w_wrap        = w_slot_end && (r_idx == c_last_idx);
  assign host.load_ack = r_load_ack;

  always_comb begin
    w_nib    = 4'h0;
    w_dp_bit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib    = r_disp_val[4*i +: 4];
        w_dp_bit = r_disp_dp[i];
      end
    end
  end

  // A digit is blank when it and every digit above it hold zero; a lit dp keeps it on.
  assign w_supp[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    if (gi == NUM_DIGITS - 1) begin : g_top
      assign w_zero_above[gi] = (r_disp_val[4*gi +: 4] == 4'h0);
    end else begin : g_mid
      assign w_zero_above[gi] = w_zero_above[gi+1] && (r_disp_val[4*gi +: 4] == 4'h0);
    end
    assign w_supp[gi] = blank_lz && w_zero_above[gi] && !r_disp_dp[gi];
  end

  always_comb begin
    w_an_on = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_an_on[i] = enable && (r_cnt >= c_blank) && !w_supp[i];
      end
    end
  end

  decoder u_dec (
    .x3 (w_nib[3]),
    .x2 (w_nib[2]),
    .x1 (w_nib[1]),
    .x0 (w_nib[0]),
    .a  (w_dec[SEG_A]),
    .b  (w_dec[SEG_B]),
    .c  (w_dec[SEG_C]),
    .d  (w_dec[SEG_D]),
    .e  (w_dec[SEG_E]),
    .f  (w_dec[SEG_F]),
    .g  (w_dec[SEG_G])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
      r_load_ack   <= 1'b0;
      frame_tick   <= 1'b0;
      seg          <= seg_polarity(SEG_OFF, c_seg_lo);
      dp           <= c_seg_lo;
      an           <= c_an_off;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
      end else if (enable) begin
        r_cnt <= r_cnt + 1'b1;
      end

      frame_tick <= w_wrap;
      r_load_ack <= w_wrap && r_pending;

      // A load on the boundary edge overrides the pending clear, so it waits a frame.
      if (w_wrap && r_pending) begin
        r_disp_val <= r_shadow_val;
        r_disp_dp  <= r_shadow_dp;
        r_pending  <= 1'b0;
      end
      if (host.load) begin
        r_shadow_val <= host.value;
        r_shadow_dp  <= host.dp_in;
        r_pending    <= 1'b1;
      end

      seg <= seg_polarity(w_dec, c_seg_lo);
      dp  <= c_seg_lo ? ~w_dp_bit : w_dp_bit;
      an  <= w_an_on ^ c_an_off;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seg_scan_ctrl : scoreboard bench for seg_scan_ctrl             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BC = 1;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ack;
    logic       tick;
  } out_t;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       blank_lz;
  logic       frame_tick;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS     (N),
    .REFRESH_DIV    (RD),
    .BLANK_CYC      (BC),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .host       (bus.slave),
    .frame_tick (frame_tick),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state of the display model
  int         m_cnt, m_idx;
  logic [15:0] m_val, m_sh_val;
  logic [3:0]  m_dp, m_sh_dp;
  logic        m_pend;
  out_t        exp_q[$];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t;
    case (n)
      4'h0: t = 7'h3F; 4'h1: t = 7'h06; 4'h2: t = 7'h5B; 4'h3: t = 7'h4F;
      4'h4: t = 7'h66; 4'h5: t = 7'h6D; 4'h6: t = 7'h7D; 4'h7: t = 7'h07;
      4'h8: t = 7'h7F; 4'h9: t = 7'h6F; 4'hA: t = 7'h77; 4'hB: t = 7'h7C;
      4'hC: t = 7'h39; 4'hD: t = 7'h5E; 4'hE: t = 7'h79; default: t = 7'h71;
    endcase
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: model predicts at the rising edge, DUT compared at the falling edge.
  task automatic step();
    out_t e;
    out_t o;
    int   lead;
    bit   wrap, supp, on;
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0; m_idx = 0; m_val = '0; m_dp = '0;
      m_sh_val = '0; m_sh_dp = '0; m_pend = 1'b0;
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ack: 1'b0, tick: 1'b0};
    end else begin
      lead = 0;
      for (int i = 0; i < N; i++) if (m_val[4*i +: 4] != 4'h0) lead = i;
      supp = blank_lz && (m_idx > lead) && !m_dp[m_idx];
      on   = enable && (m_cnt >= BC) && !supp;
      wrap = enable && (m_cnt == RD - 1) && (m_idx == N - 1);
      e.an   = on ? ~(4'b0001 << m_idx) : 4'hF;
      e.seg  = ~hex7(m_val[4*m_idx +: 4]);
      e.dp   = ~m_dp[m_idx];
      e.ack  = wrap && m_pend;
      e.tick = wrap;
      if (enable) begin
        if (m_cnt == RD - 1) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % N;
        end else begin
          m_cnt++;
        end
      end
      if (wrap && m_pend) begin
        m_val = m_sh_val; m_dp = m_sh_dp; m_pend = 1'b0;
      end
      if (bus.load) begin
        m_sh_val = bus.value; m_sh_dp = bus.dp_in; m_pend = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    o = '{an: an, seg: seg, dp: dp, ack: bus.load_ack, tick: frame_tick};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL scoreboard observed an=%b seg=%h dp=%b ack=%b tick=%b expected an=%b seg=%h dp=%b ack=%b tick=%b",
             o.an, o.seg, o.dp, o.ack, o.tick, e.an, e.seg, e.dp, e.ack, e.tick);
    end
    #1;
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    bus.load = 1'b1; bus.value = v; bus.dp_in = d;
    step();
    bus.load = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      seen = bus.load_ack;
    end
    chk(tag, seen, 1'b1);
  endtask

  initial begin
    int n0, n1, nb, acks;
    logic [3:0] prev;
    bit found;
    rst_n = 1'b0; enable = 1'b1; blank_lz = 1'b0;
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0;
    repeat (2) step();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_ack", bus.load_ack, 1'b0);
    rst_n = 1'b1;
    #1 chk("rel_an", an, 4'hF);
    chk("rel_seg", seg, 7'h7F);

    // 1: reset mid-scan with a pending load
    repeat (6) step();
    load_val(16'h1234, 4'h0);
    repeat (3) step();
    rst_n = 1'b0;
    #1 chk("async_an", an, 4'hF);
    chk("async_seg", seg, 7'h7F);
    chk("async_dp", dp, 1'b1);
    chk("async_ack", bus.load_ack, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    #1 chk("after_rst_seg", seg, 7'h7F);
    step(); step();
    chk("idx_restart_an", an, 4'b1110);
    acks = 0;
    for (int k = 0; k < 18; k++) begin step(); acks += int'(bus.load_ack); end
    chk("discarded_no_ack", acks, 0);

    // 2: basic load and per-slot contents
    load_val(16'h12AF, 4'h0);
    wait_ack("ack_12AF");
    chk("tick_with_ack", frame_tick, 1'b1);
    n0 = 0; n1 = 0; nb = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (an == 4'b1110) begin n0++; if (seg !== 7'h0E) nb++; end
      if (an == 4'b1101) begin n1++; if (seg !== 7'h08) nb++; end
    end
    chk("an0_cycles", n0, 3);
    chk("an1_cycles", n1, 3);
    chk("slot_seg_bad", nb, 0);

    // 3: two loads in one frame, last wins
    load_val(16'h0001, 4'h0);
    load_val(16'h0003, 4'h0);
    acks = 0; n0 = 0; nb = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      acks += int'(bus.load_ack);
      if (an == 4'b1110 && seg === 7'h79) nb++;
      if (an == 4'b1110 && seg === 7'h30) n0++;
    end
    chk("single_ack", acks, 1);
    chk("never_shows_1", nb, 0);
    chk("d0_shows_3", n0 >= 3, 1'b1);

    // 4: leading-zero suppression
    blank_lz = 1'b1;
    load_val(16'h0070, 4'h0);
    wait_ack("ack_0070");
    n0 = 0; n1 = 0; nb = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (an[3] == 1'b0 || an[2] == 1'b0) nb++;
      if (an == 4'b1101 && seg === 7'h78) n1++;
      if (an == 4'b1110 && seg === 7'h40) n0++;
    end
    chk("lz_upper_off", nb, 0);
    chk("lz_d1_seven", n1, 3);
    chk("lz_d0_zero", n0, 3);
    load_val(16'h0000, 4'h0);
    wait_ack("ack_0000");
    n0 = 0; nb = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (an[3:1] != 3'b111) nb++;
      if (an == 4'b1110 && seg === 7'h40) n0++;
    end
    chk("zero_only_d0", nb, 0);
    chk("zero_d0_lit", n0, 3);

    // 5: decimal point overrides suppression
    load_val(16'h0005, 4'b0100);
    wait_ack("ack_0005");
    n0 = 0; nb = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (an[3] == 1'b0) nb++;
      if (an == 4'b1011 && seg === 7'h40 && dp === 1'b0) n0++;
    end
    chk("dp_d3_off", nb, 0);
    chk("dp_d2_lit", n0, 3);

    // 6: load on the boundary edge
    blank_lz = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin step(); found = frame_tick; end
    chk("find_tick", found, 1'b1);
    load_val(16'h4321, 4'h0);
    repeat (14) step();
    load_val(16'h8765, 4'h0);
    chk("edge_ack_old", bus.load_ack, 1'b1);
    chk("edge_tick", frame_tick, 1'b1);
    acks = 0; n0 = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      acks += int'(bus.load_ack);
      if (an == 4'b1110 && seg === 7'h79) n0++;
    end
    chk("edge_no_early_ack", acks, 0);
    chk("edge_old_shown", n0, 3);
    step();
    chk("edge_new_ack", bus.load_ack, 1'b1);

    // enable=0 freezes the scan
    prev = an; found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      found = (an == 4'b1101) && (prev != 4'b1101);
      prev = an;
    end
    chk("find_d1", found, 1'b1);
    enable = 1'b0;
    nb = 0;
    for (int k = 0; k < 10; k++) begin step(); if (an != 4'hF) nb++; end
    chk("disabled_an_off", nb, 0);
    enable = 1'b1;
    step();
    chk("idx_frozen", an, 4'b1101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
